// File: rtl/counter_10_pkg.sv
// Shared definitions for the counter_10 tick generator.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
//
// Contents:
//   DIV_DEFAULT    default division ratio (10)
//   cnt_width()    smallest counter width w with 2^w >= div (at least 1)
//   CNT_W_DEFAULT  counter width for DIV_DEFAULT
//   cnt_t          counter type at the default width

package counter_10_pkg;

    localparam int DIV_DEFAULT = 10;

    // Constant function, evaluated at elaboration time only. The loop is
    // bounded so it stays friendly to every synthesis front end.
    function automatic int cnt_width(input int div);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < div) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    localparam int CNT_W_DEFAULT = cnt_width(DIV_DEFAULT);

    typedef logic [CNT_W_DEFAULT-1:0] cnt_t;

endpackage : counter_10_pkg

// File: rtl/counter_10_mod_counter.sv
// Free-running wrap-at-DIV counter with a look-ahead terminal flag.
// Latency: count updates on every rising clk edge; next_is_terminal is combinational from count.
// Backpressure: none, the counter never stalls.
//
// Ports:
//   clk               rising-edge clock
//   rst               asynchronous active-low reset (0 clears count)
//   count             current count, 0 .. DIV-1
//   next_is_terminal  1 when the value loaded at the next edge is DIV-1

module mod_counter
    import counter_10_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int CNT_W = cnt_width(DIV)
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] count,
    output logic             next_is_terminal
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_nxt;

    // A compare of ">= LAST" instead of "== LAST" folds the wrap and the
    // recovery from an upset into an unused code into the same path: any
    // code at or beyond the terminal value returns to 0 on the next edge.
    always_comb begin
        count_nxt = count + CNT_W'(1);
        if (count >= LAST) begin
            count_nxt = '0;
        end
    end

    // Look-ahead decode so the top can register the tick and have it high
    // in exactly the cycle where count == DIV-1. Since DIV >= 2, the
    // recovery value 0 never decodes as terminal, so an upset also drops
    // the tick on the next edge.
    assign next_is_terminal = (count_nxt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else begin
            count <= count_nxt;
        end
    end

endmodule : mod_counter

// File: rtl/counter_10.sv
// Modulo-DIV tick generator: registered one-cycle pulse every DIV clk cycles.
// Latency: pulse is high in the same cycle count == DIV-1 (flop fed from next-count decode).
// Backpressure: none, free-running whenever reset is released.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset; clears count and pulse at once
//   pulse  registered tick, high for one clk cycle out of every DIV
//
// Build option: define COUNTER_10_CHECK_EN to compile in simulation-only
// checks (pulse width, pulse spacing, count range, pulse low in reset,
// parameter legality). The synthesized logic is the same either way.

module counter_10
    import counter_10_pkg::*;
#(
    parameter int DIV   = DIV_DEFAULT,
    parameter int CNT_W = cnt_width(DIV)
) (
    input  logic clk,
    input  logic rst,
    output logic pulse
);

    logic [CNT_W-1:0] count;
    logic             next_is_terminal;

    mod_counter #(
        .DIV   (DIV),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk              (clk),
        .rst              (rst),
        .count            (count),
        .next_is_terminal (next_is_terminal)
    );

    // The tick leaves through a flop so the port never sees a decode glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pulse <= 1'b0;
        end else begin
            pulse <= next_is_terminal;
        end
    end

`ifdef COUNTER_10_CHECK_EN

    // Parameter legality, caught at elaboration.
    if (DIV < 2 || DIV > 65535 || (64'(1) << CNT_W) < 64'(DIV)) begin : g_bad_param
        $error("counter_10: illegal DIV=%0d / CNT_W=%0d", DIV, CNT_W);
    end

    // chk_gap counts cycles since the last observed pulse; chk_seen gates
    // the spacing check until one full period has been seen after reset.
    logic        chk_pulse_q;
    logic        chk_seen;
    int unsigned chk_gap;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            chk_pulse_q <= 1'b0;
            chk_seen    <= 1'b0;
            chk_gap     <= 0;
        end else begin
            chk_pulse_q <= pulse;
            if (pulse) begin
                chk_seen <= 1'b1;
                chk_gap  <= 1;
            end else begin
                chk_gap  <= chk_gap + 1;
            end
        end
    end

    // Sampled at the rising edge: all values seen here are pre-edge.
    always @(posedge clk) begin
        if (rst) begin
            assert (!(pulse && chk_pulse_q))
                else $error("counter_10: pulse high for two consecutive cycles");
            if (pulse && chk_seen) begin
                assert (chk_gap == DIV)
                    else $error("counter_10: pulse spacing %0d, expected %0d", chk_gap, DIV);
            end
            assert (int'(count) < DIV)
                else $error("counter_10: count %0d out of range", count);
        end
    end

    // Mid-cycle sample avoids racing the asynchronous clear.
    always @(negedge clk) begin
        if (!rst) begin
            assert (!pulse)
                else $error("counter_10: pulse high during reset");
        end
    end

`else

    // count only feeds the checks; keep it visible without a dangling net.
    logic count_unused;
    assign count_unused = ^count;

`endif

endmodule : counter_10

// File: tb/tb_counter_10.sv
// Directed bench for counter_10 at DIV=10 and DIV=3.
// Latency: expected pulse/count derived from edge number since reset release.
// Backpressure: n/a.

module tb_counter_10;

    logic clk;
    logic rst;
    logic rst3;
    logic pulse;
    logic pulse3;

    int n_tests;
    int n_fail;

    counter_10 dut (
        .clk   (clk),
        .rst   (rst),
        .pulse (pulse)
    );

    counter_10 #(.DIV(3)) dut3 (
        .clk   (clk),
        .rst   (rst3),
        .pulse (pulse3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d, expected %0d", tag, $time, got, exp);
        end
    endtask

    // Advance one edge, then compare the DIV=10 instance against edge k
    // counted from reset release.
    task automatic tick_chk(input string tag, input int k);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".pulse"}, 32'(pulse), 32'((k % 10) == 9));
        chk({tag, ".count"}, 32'(dut.count), 32'(k % 10));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        rst3    = 1'b0;

        // Held in reset with the clock running.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_hold.pulse", 32'(pulse), 32'd0);
            chk("rst_hold.count", 32'(dut.count), 32'd0);
            chk("rst_hold.pulse3", 32'(pulse3), 32'd0);
        end

        // Release both between edges; 50 edges of free-running.
        rst  = 1'b1;
        rst3 = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick_chk("run", k);
            chk("div3.pulse", 32'(pulse3), 32'((k % 3) == 2));
        end

        // Run into the next pulse (edge 59), then reset mid-cycle.
        for (int k = 51; k <= 59; k++) begin
            tick_chk("to_pulse", k);
        end
        rst = 1'b0;
        #1;
        chk("async_rst.pulse", 32'(pulse), 32'd0);
        chk("async_rst.count", 32'(dut.count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("async_hold.pulse", 32'(pulse), 32'd0);
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick_chk("after_async", k);
        end

        // Restart from count 0, stop at count 5, reset for two edges.
        rst = 1'b0;
        #1;
        rst = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick_chk("to_five", k);
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("mid_rst.pulse", 32'(pulse), 32'd0);
            chk("mid_rst.count", 32'(dut.count), 32'd0);
        end
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick_chk("after_mid", k);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_counter_10
